// File: rtl/delay_line.sv
// Programmable-depth delay line for valid-tagged words, with hold, flush on
// re-programming, occupancy count and an out-of-range selection flag.
module delay_line #(
  parameter  int WIDTH         = 32,
  parameter  int MAX_DELAY     = 8,
  parameter  int DEFAULT_DELAY = 1,
  localparam int SW            = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    delay_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    delay_cur,
  output logic [SW-1:0]    pending,
  output logic             sel_err
);

  logic [MAX_DELAY:1] vld;
  logic [WIDTH-1:0]   dat [1:MAX_DELAY];

  logic sel_legal;
  logic reprogram;

  assign sel_legal = (delay_sel != '0) && (delay_sel <= SW'(MAX_DELAY));
  assign reprogram = sel_legal && (delay_sel != delay_cur);

  // A legal change of depth empties the whole line in the same edge, so no
  // sample ever leaves with a delay it was not accepted under.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld       <= '0;
      delay_cur <= SW'(DEFAULT_DELAY);
      sel_err   <= 1'b0;
      for (int k = 1; k <= MAX_DELAY; k++) dat[k] <= '0;
    end else begin
      sel_err <= !sel_legal;
      if (reprogram) begin
        delay_cur <= delay_sel;
        vld       <= '0;
        for (int k = 1; k <= MAX_DELAY; k++) dat[k] <= '0;
      end else if (!hold) begin
        vld[1] <= in_valid;
        dat[1] <= in_valid ? in_data : '0;
        for (int k = MAX_DELAY; k >= 2; k--) begin
          vld[k] <= vld[k-1];
          dat[k] <= dat[k-1];
        end
      end
    end
  end

  // Output tap and occupancy both ignore stages beyond the selected depth.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    pending   = '0;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (SW'(k) == delay_cur) begin
        out_valid = vld[k];
        out_data  = dat[k];
      end
      if (SW'(k) <= delay_cur) pending = pending + SW'(vld[k]);
    end
  end

endmodule
